// File: rtl/fir_avg_pkg.sv
// Shared types and helpers for the multi-channel moving-average filter.
// Holds the controller state encoding and the window-length clamp.
package fir_avg_pkg;

  localparam int LEN_W = 3;

  typedef enum logic [1:0] {
    FLUSH,
    IDLE,
    CALC,
    OUT
  } state_t;

  // Window exponents beyond the buffer depth saturate at the deepest window.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned       lmax);
    if (32'(len) > lmax) return LEN_W'(lmax);
    return len;
  endfunction

endpackage

// File: rtl/fir_avg_mc_if.sv
// Sample-set stream between codec read side and filter, and filter and codec write side.
// One packed word carries NUM_CH signed samples, channel 0 in the LSBs.
interface fir_avg_mc_if #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2
);

  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] data_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out
  );

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out
  );

endinterface

// File: rtl/fir_avg_ring.sv
// One channel of the moving average: circular sample buffer plus running sum.
// y is combinational and reflects the sum after the pending write of x.
module fir_avg_ring
  import fir_avg_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic                         flush_en,
  input  logic        [ADDR_WIDTH-1:0] flush_addr,
  input  logic        [ADDR_WIDTH-1:0] wp,
  input  logic        [LEN_W-1:0]      len_q,
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int AW1   = ADDR_WIDTH + 1;

  logic signed [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic signed [SUM_W-1:0]      sum_q;
  logic signed [SUM_W-1:0]      sum_d;
  logic signed [SUM_W-1:0]      x_ext;
  logic signed [SUM_W-1:0]      old_ext;
  logic signed [SUM_W-1:0]      shifted;
  logic signed [DATA_WIDTH-1:0] old;
  logic        [AW1-1:0]        win;
  logic        [AW1-1:0]        rd_full;
  logic        [ADDR_WIDTH-1:0] rd_idx;

  // A full-depth window reads the slot about to be overwritten.
  always_comb begin
    win     = AW1'(1) << len_q;
    rd_full = {1'b0, wp} - win;
    rd_idx  = rd_full[ADDR_WIDTH-1:0];
    old     = buf_q[rd_idx];
    x_ext   = SUM_W'(x);
    old_ext = SUM_W'(old);
    sum_d   = sum_q + x_ext - old_ext;
    shifted = sum_d >>> len_q;
    y       = shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (flush_en) begin
      sum_q <= '0;
    end else if (wr_en) begin
      sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (flush_en) begin
      buf_q[flush_addr] <= '0;
    end else if (wr_en) begin
      buf_q[wp] <= x;
    end
  end

endmodule

// File: rtl/fir_avg_mc.sv
// Multi-channel moving-average FIR with run-time power-of-two window, bypass and clear.
// Channels are evaluated one per cycle after each accepted sample set.
module fir_avg_mc
  import fir_avg_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] len_log2,
  input  logic             bypass,
  input  logic             clear,
  fir_avg_mc_if.slave      strm
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BUS_W = NUM_CH * DATA_WIDTH;

  state_t                       state_q, state_d;
  logic        [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic        [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic        [LEN_W-1:0]      len_q, len_d;
  logic        [CH_W-1:0]       ch_q, ch_d;
  logic        [BUS_W-1:0]      x_q, x_d;
  logic                         byp_q, byp_d;
  logic        [BUS_W-1:0]      out_q, out_d;

  logic        [LEN_W-1:0]      len_clamped;
  logic                         len_change;
  logic                         flush_en;
  logic        [NUM_CH-1:0]     wr_en_ch;
  logic signed [DATA_WIDTH-1:0] y_ch [NUM_CH];
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic signed [DATA_WIDTH-1:0] res;

  assign len_clamped = clamp_len(len_log2, ADDR_WIDTH);
  assign len_change  = (len_clamped != len_q);
  assign flush_en    = (state_q == FLUSH);

  // Clear and window changes outrank a pending sample in the same cycle.
  assign strm.in_ready  = (state_q == IDLE) && !clear && !len_change;
  assign strm.out_valid = (state_q == OUT);
  assign strm.data_out  = out_q;

  always_comb begin
    wr_en_ch = '0;
    if (state_q == CALC) wr_en_ch[ch_q] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fir_avg_ring #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en_ch[i]),
      .flush_en  (flush_en),
      .flush_addr(cnt_q),
      .wp        (wp_q),
      .len_q     (len_q),
      .x         (x_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .y         (y_ch[i])
    );
  end

  assign x_cur = x_q[ch_q*DATA_WIDTH +: DATA_WIDTH];
  assign res   = byp_q ? x_cur : y_ch[ch_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    len_d   = len_q;
    ch_d    = ch_q;
    x_d     = x_q;
    byp_d   = byp_q;
    out_d   = out_q;
    unique case (state_q)
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = IDLE;
          wp_d    = '0;
          len_d   = len_clamped;
        end
      end
      IDLE: begin
        if (clear || len_change) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (strm.in_valid) begin
          x_d     = strm.data_in;
          byp_d   = bypass;
          ch_d    = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        out_d[ch_q*DATA_WIDTH +: DATA_WIDTH] = res;
        ch_d = ch_q + 1'b1;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          wp_d    = wp_q + 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (strm.out_ready) state_d = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FLUSH;
      cnt_q   <= '0;
      wp_q    <= '0;
      len_q   <= '0;
      ch_q    <= '0;
      x_q     <= '0;
      byp_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      len_q   <= len_d;
      ch_q    <= ch_d;
      x_q     <= x_d;
      byp_q   <= byp_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_fir_avg_mc.sv
// Directed bench for fir_avg_mc: flush timing, averaging, floor rounding,
// extremes, backpressure, clear/len-change flushes, bypass and pointer wrap.
module tb_fir_avg_mc;
  import fir_avg_pkg::*;

  localparam int DW = 24;
  localparam int AW = 4;
  localparam int NC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] len_log2 = 3'd0;
  logic       bypass = 1'b0;
  logic       clear = 1'b0;
  int         checks = 0;
  int         errors = 0;

  fir_avg_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

  fir_avg_mc #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_CH    (NC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .len_log2(len_log2),
    .bypass  (bypass),
    .clear   (clear),
    .strm    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pushes one set, waits for the result and completes the output handshake (out_ready assumed 1).
  task automatic send(input logic signed [DW-1:0] a0, input logic signed [DW-1:0] a1,
                      input logic byp, output logic signed [DW-1:0] r0,
                      output logic signed [DW-1:0] r1, output int lat);
    int n;
    r0 = '0; r1 = '0; lat = 0;
    bus.data_in = {a1, a0};
    bus.in_valid = 1'b1;
    bypass = byp;
    #1;
    n = 0;
    while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_accept: in_ready=%0b, required 1 within 200 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bypass = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL send_out: out_valid=%0b, required 1 within 50 cycles", bus.out_valid);
      return;
    end
    r0 = bus.data_out[DW-1:0];
    r1 = bus.data_out[2*DW-1:DW];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n;
    bit ov_seen;
    reset = 1'b0;
    len_log2 = 3'd2;
    bus.in_valid = 1'b1;
    bus.data_in = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b, required 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
    checks++;
    if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h, required 0", bus.data_out); end
    reset = 1'b1;
    n = 0;
    ov_seen = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      if (bus.out_valid) ov_seen = 1;
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL reset_flush_cycles: got %0d, required 16", n); end
    checks++;
    if (ov_seen) begin errors++; $display("FAIL reset_flush_out_valid: got 1, required 0"); end
  endtask

  task automatic test_window4();
    int xin [5] = '{100, 200, 300, 400, 500};
    int exp0[5] = '{25, 75, 150, 250, 350};
    logic signed [DW-1:0] r0, r1, e;
    int lat;
    len_log2 = 3'd2;
    for (int i = 0; i < 5; i++) begin
      send(DW'(xin[i]), '0, 1'b0, r0, r1, lat);
      e = DW'(exp0[i]);
      checks++;
      if (r0 !== e) begin errors++; $display("FAIL win4_ch0[%0d]: got %0d, required %0d", i, r0, e); end
      checks++;
      if (r1 !== '0) begin errors++; $display("FAIL win4_ch1[%0d]: got %0d, required 0", i, r1); end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL win4_latency[%0d]: got %0d, required 3", i, lat); end
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL win4_out_valid_drop: got %0b, required 0", bus.out_valid); end
  endtask

  task automatic test_floor_and_extremes();
    logic signed [DW-1:0] r0, r1;
    int lat;
    len_log2 = 3'd1;
    send('0, -DW'(3), 1'b0, r0, r1, lat);
    checks++;
    if (r1 !== -DW'(2)) begin errors++; $display("FAIL floor_first: got %0d, required -2", r1); end
    checks++;
    if (r0 !== '0) begin errors++; $display("FAIL floor_ch0: got %0d, required 0", r0); end
    send('0, -DW'(3), 1'b0, r0, r1, lat);
    checks++;
    if (r1 !== -DW'(3)) begin errors++; $display("FAIL floor_second: got %0d, required -3", r1); end
    len_log2 = 3'd4;
    for (int k = 0; k < 16; k++) begin
      send(DW'(24'h7FFFFF), DW'(24'h800000), 1'b0, r0, r1, lat);
      if (k == 0) begin
        checks++;
        if (r0 !== DW'(24'h07FFFF)) begin errors++; $display("FAIL max_ramp: got %h, required 07ffff", r0); end
        checks++;
        if (r1 !== DW'(24'hF80000)) begin errors++; $display("FAIL min_ramp: got %h, required f80000", r1); end
      end
      if (k == 15) begin
        checks++;
        if (r0 !== DW'(24'h7FFFFF)) begin errors++; $display("FAIL max_full: got %h, required 7fffff", r0); end
        checks++;
        if (r1 !== DW'(24'h800000)) begin errors++; $display("FAIL min_full: got %h, required 800000", r1); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2*DW-1:0] snap;
    int n, lat;
    bus.out_ready = 1'b0;
    bus.data_in = {24'h000000, 24'h000010};
    bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    snap = bus.data_out;
    checks++;
    if (snap !== {24'h880000, 24'h780000}) begin errors++; $display("FAIL bp_value: got %h, required 880000780000", snap); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== snap || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%0b data=%h ready=%0b, required 1/%h/0", c, bus.out_valid, bus.data_out, bus.in_ready, snap);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%0b ready=%0b, required 0/1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL bp_next_latency: got %0d, required 3", lat); end
    checks++;
    if (bus.data_out !== {24'h900000, 24'h700001}) begin errors++; $display("FAIL bp_next_value: got %h, required 900000700001", bus.data_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_and_len_change();
    logic signed [DW-1:0] r0, r1;
    int n, lat;
    bit ov_seen;
    len_log2 = 3'd2;
    send(DW'(400), -DW'(400), 1'b0, r0, r1, lat);
    checks++;
    if (r0 !== DW'(100) || r1 !== -DW'(100)) begin errors++; $display("FAIL pre_clear: got %0d/%0d, required 100/-100", r0, r1); end
    bus.data_in = {-DW'(400), DW'(400)};
    bus.in_valid = 1'b1;
    clear = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %0b, required 0", bus.in_ready); end
    @(posedge clk); #1;
    clear = 1'b0;
    n = 0;
    ov_seen = 0;
    while (!bus.in_ready && n < 100) begin
      if (bus.out_valid) ov_seen = 1;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== 16 || ov_seen) begin errors++; $display("FAIL clear_flush: cycles=%0d out_valid_seen=%0b, required 16/0", n, ov_seen); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (bus.data_out !== {-DW'(100), DW'(100)}) begin errors++; $display("FAIL clear_result: got %h, required %h", bus.data_out, {-DW'(100), DW'(100)}); end
    @(posedge clk); #1;
    len_log2 = 3'd3;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL len_change_in_ready: got %0b, required 0", bus.in_ready); end
    send(DW'(800), -DW'(800), 1'b0, r0, r1, lat);
    checks++;
    if (r0 !== DW'(100) || r1 !== -DW'(100)) begin errors++; $display("FAIL len_change_result: got %0d/%0d, required 100/-100", r0, r1); end
  endtask

  task automatic test_bypass_and_wrap();
    logic signed [DW-1:0] r0, r1, e0, e1;
    int lat, s;
    len_log2 = 3'd1;
    send(DW'(1234), -DW'(5), 1'b1, r0, r1, lat);
    checks++;
    if (r0 !== DW'(1234) || r1 !== -DW'(5)) begin errors++; $display("FAIL bypass_w2: got %0d/%0d, required 1234/-5", r0, r1); end
    send(DW'(2000), DW'(7), 1'b0, r0, r1, lat);
    checks++;
    if (r0 !== DW'(1617) || r1 !== DW'(1)) begin errors++; $display("FAIL after_bypass_w2: got %0d/%0d, required 1617/1", r0, r1); end
    len_log2 = 3'd0;
    send(DW'(1234), -DW'(5), 1'b1, r0, r1, lat);
    checks++;
    if (r0 !== DW'(1234) || r1 !== -DW'(5)) begin errors++; $display("FAIL bypass_w1: got %0d/%0d, required 1234/-5", r0, r1); end
    send(-DW'(77), DW'(55), 1'b0, r0, r1, lat);
    checks++;
    if (r0 !== -DW'(77) || r1 !== DW'(55)) begin errors++; $display("FAIL after_bypass_w1: got %0d/%0d, required -77/55", r0, r1); end
    len_log2 = 3'd4;
    for (int n = 1; n <= 20; n++) begin
      send(DW'(n), -DW'(n), 1'b0, r0, r1, lat);
      s = 0;
      for (int k = ((n > 16) ? n - 15 : 1); k <= n; k++) s += k;
      e0 = DW'(s >>> 4);
      e1 = DW'((-s) >>> 4);
      checks++;
      if (r0 !== e0 || r1 !== e1) begin errors++; $display("FAIL wrap[%0d]: got %0d/%0d, required %0d/%0d", n, r0, r1, e0, e1); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_window4();
    test_floor_and_extremes();
    test_backpressure();
    test_clear_and_len_change();
    test_bypass_and_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
